reaction_controller: RTL

Top-level sequencer for the reaction-timer game. After a start press it waits a pseudo-random delay, lights the stimulus LED, and measures the player's reaction time in milliseconds. It then holds the result on the display by driving `display_wait` into the display-hold counter, and returns to idle on that counter's `display_wait_done`. Early presses (cheats) and no-response timeouts are flagged and shown through the same hold path.

---
 rtl/reaction_pkg.sv | 23 ++
 rtl/ms_tick_gen.sv | 28 ++
 rtl/reaction_controller.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencer.
package reaction_pkg;

  localparam int unsigned MsW = 14;

  typedef logic [MsW-1:0] ms_t;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StReact,
    StShow
  } state_t;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LfsrTaps) : (s >> 1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; clear restarts the period.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == Last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign tick = (r_cnt == Last);

endmodule

// File: rtl/reaction_controller.sv
// Reaction-timer sequencer: random pre-stimulus delay, ms reaction count, cheat/timeout
// flags and a display hold released by a fresh rising edge of display_wait_done.
module reaction_controller
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 100000,
  parameter int unsigned DELAY_MIN_MS    = 1000,
  parameter int unsigned DELAY_RAND_BITS = 10,
  parameter int unsigned MAX_MS          = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        display_wait_done,
  output logic        led,
  output logic        display_wait,
  output logic [13:0] rt_ms,
  output logic        rt_valid,
  output logic        cheat,
  output logic        timeout
);

  localparam ms_t MaxMs    = ms_t'(MAX_MS);
  localparam ms_t DelayMin = ms_t'(DELAY_MIN_MS);

  state_t      r_state, w_state_next;
  ms_t         r_ms, w_ms_next;
  ms_t         r_delay, w_delay_next;
  ms_t         r_rt_ms, w_rt_ms_next;
  logic [15:0] r_lfsr;
  logic        r_done_prev;
  logic        r_led, r_display_wait, r_rt_valid, r_cheat, r_timeout;
  logic        w_rt_valid_next, w_cheat_next, w_timeout_next;
  logic        w_tick, w_clear, w_done_rise, w_sat;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(w_clear),
    .tick (w_tick)
  );

  // Only a fresh rising edge ends SHOW; a level left high by the last hold does not.
  assign w_done_rise = display_wait_done & ~r_done_prev;
  assign w_sat       = (r_ms == MaxMs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StDelay;
      StDelay: begin
        if (stop) begin
          w_state_next = StShow;
        end else if (r_ms == r_delay) begin
          w_state_next = StReact;
        end
      end
      StReact: if (stop || w_sat) w_state_next = StShow;
      StShow:  if (w_done_rise) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_clear         = 1'b0;
    w_ms_next       = r_ms;
    w_delay_next    = r_delay;
    w_rt_ms_next    = r_rt_ms;
    w_rt_valid_next = 1'b0;
    w_cheat_next    = r_cheat;
    w_timeout_next  = r_timeout;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_clear        = 1'b1;
          w_ms_next      = '0;
          w_delay_next   = DelayMin + ms_t'(r_lfsr[DELAY_RAND_BITS-1:0]);
          w_cheat_next   = 1'b0;
          w_timeout_next = 1'b0;
        end
      end
      StDelay: begin
        if (stop) begin
          w_cheat_next = 1'b1;
        end else if (r_ms == r_delay) begin
          w_clear   = 1'b1;
          w_ms_next = '0;
        end else if (w_tick) begin
          w_ms_next = r_ms + ms_t'(1);
        end
      end
      StReact: begin
        // A stop coinciding with saturation still counts as a genuine capture.
        if (stop) begin
          w_rt_ms_next    = r_ms;
          w_rt_valid_next = 1'b1;
        end else if (w_sat) begin
          w_rt_ms_next   = MaxMs;
          w_timeout_next = 1'b1;
        end else if (w_tick) begin
          w_ms_next = r_ms + ms_t'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr         <= LfsrSeed;
      r_done_prev    <= 1'b0;
      r_ms           <= '0;
      r_delay        <= '0;
      r_rt_ms        <= '0;
      r_rt_valid     <= 1'b0;
      r_cheat        <= 1'b0;
      r_timeout      <= 1'b0;
      r_led          <= 1'b0;
      r_display_wait <= 1'b0;
    end else begin
      r_lfsr         <= lfsr_next(r_lfsr);
      r_done_prev    <= display_wait_done;
      r_ms           <= w_ms_next;
      r_delay        <= w_delay_next;
      r_rt_ms        <= w_rt_ms_next;
      r_rt_valid     <= w_rt_valid_next;
      r_cheat        <= w_cheat_next;
      r_timeout      <= w_timeout_next;
      r_led          <= (w_state_next == StReact);
      r_display_wait <= (w_state_next == StShow);
    end
  end

  assign led          = r_led;
  assign display_wait = r_display_wait;
  assign rt_ms        = r_rt_ms;
  assign rt_valid     = r_rt_valid;
  assign cheat        = r_cheat;
  assign timeout      = r_timeout;

endmodule
